// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word type, reset/NOP constants and PC helpers.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC = 32'h0000_0000;
  localparam word_t NOP_INST = 32'h0000_0000;
  localparam word_t PC_STEP  = 32'd4;

  // Word-align an address by clearing its byte-offset bits.
  function automatic word_t pc_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

  // A target is misaligned when either byte-offset bit is set.
  function automatic logic pc_misaligned(input word_t a);
    return |a[1:0];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Squash takes priority over hold; while squashed,
// the PC fields keep their previous values and only the instruction and
// valid bit are cleared.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter word_t NOP = NOP_INST
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        hold,
  input  logic        squash,
  input  logic [31:0] inst_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  output logic [31:0] inst_q,
  output logic [31:0] pc_q,
  output logic [31:0] pc_plus4_q,
  output logic        valid_q
);

  // Load, squash or hold the IF/ID contents.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      inst_q     <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (squash) begin
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (!hold) begin
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection, sticky
// misaligned-target flag and delivered-instruction counter. The PC is
// deliberately never masked to ROM size; the ROM aliases on its own.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC_P = RESET_PC,
  parameter word_t NOP_INST_P = NOP_INST
) (
  input  logic        Clk,
  input  logic        Clrn,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  output logic [31:0] IdInst,
  output logic [31:0] IdPc,
  output logic [31:0] IdPcPlus4,
  output logic        IdValid,
  output logic        AddrErr,
  output logic [31:0] FetchCount
);

  word_t pc, pc_next, pc_plus4;
  logic  advance;

  assign Addr     = pc;
  assign pc_plus4 = pc + PC_STEP;
  assign advance  = !Redirect && !Stall;

  // Next PC: redirect beats stall, stall beats sequential advance.
  always_comb begin
    pc_next = pc;
    if (Redirect)     pc_next = pc_align(RedirectPc);
    else if (!Stall)  pc_next = pc_plus4;
  end

  // PC register.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) pc <= RESET_PC_P;
    else       pc <= pc_next;
  end

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)                                   AddrErr <= 1'b0;
    else if (Redirect && pc_misaligned(RedirectPc)) AddrErr <= 1'b1;
  end

  // Count instructions actually handed to ID.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)        FetchCount <= '0;
    else if (advance) FetchCount <= FetchCount + 32'd1;
  end

  if_id_reg #(.NOP(NOP_INST_P)) u_if_id (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .hold       (Stall),
    .squash     (Redirect),
    .inst_d     (Inst),
    .pc_d       (pc),
    .pc_plus4_d (pc_plus4),
    .inst_q     (IdInst),
    .pc_q       (IdPc),
    .pc_plus4_q (IdPcPlus4),
    .valid_q    (IdValid)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: the stimulus process applies a cycle's
// inputs, predicts the post-edge state from the fetch rules and queues it;
// the monitor pops one expectation after every rising edge and compares.
module tb_inst_fetch;

  typedef struct {
    logic [31:0] addr, inst, pc, p4, cnt;
    logic        valid, err;
  } exp_t;

  logic        Clk = 1'b0, Clrn = 1'b0;
  logic [31:0] Addr, Inst, RedirectPc = '0;
  logic        Stall = 1'b0, Redirect = 1'b0;
  logic [31:0] IdInst, IdPc, IdPcPlus4, FetchCount;
  logic        IdValid, AddrErr;

  logic [31:0] rom [32];
  exp_t        sb [$];
  int          errors = 0, checks = 0;

  // Architectural model state.
  logic [31:0] m_pc, m_inst, m_idpc, m_p4, m_cnt;
  logic        m_valid, m_err;

  assign Inst = rom[Addr[6:2]];

  inst_fetch dut (
    .Clk(Clk), .Clrn(Clrn), .Addr(Addr), .Inst(Inst), .Stall(Stall),
    .Redirect(Redirect), .RedirectPc(RedirectPc), .IdInst(IdInst),
    .IdPc(IdPc), .IdPcPlus4(IdPcPlus4), .IdValid(IdValid),
    .AddrErr(AddrErr), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_idpc = 32'h0; m_p4 = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic check_reset_outputs();
    cmp("rst_addr", Addr, 32'h0);
    cmp("rst_idinst", IdInst, 32'h0);
    cmp("rst_idpc", IdPc, 32'h0);
    cmp("rst_idpc4", IdPcPlus4, 32'h0);
    cmp("rst_valid", {31'b0, IdValid}, 32'h0);
    cmp("rst_err", {31'b0, AddrErr}, 32'h0);
    cmp("rst_cnt", FetchCount, 32'h0);
  endtask

  // Hold reset across two edges, release away from the edge.
  task automatic do_reset();
    Clrn = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    repeat (2) @(posedge Clk);
    #2 Clrn = 1'b1;
  endtask

  // One cycle: drive inputs, predict, wait for the edge. Called at posedge+2.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    exp_t e;
    Stall = st; Redirect = rd; RedirectPc = rpc;
    if (rd) begin
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
      m_pc = rpc & 32'hFFFF_FFFC;
      m_inst = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_inst = rom[m_pc[6:2]];
      m_idpc = m_pc;
      m_p4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
    e.addr = m_pc; e.inst = m_inst; e.pc = m_idpc; e.p4 = m_p4;
    e.cnt = m_cnt; e.valid = m_valid; e.err = m_err;
    sb.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  // Monitor: after every edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("addr", Addr, e.addr);
        cmp("idinst", IdInst, e.inst);
        cmp("idpc", IdPc, e.pc);
        cmp("idpc4", IdPcPlus4, e.p4);
        cmp("valid", {31'b0, IdValid}, {31'b0, e.valid});
        cmp("adderr", {31'b0, AddrErr}, {31'b0, e.err});
        cmp("fcount", FetchCount, e.cnt);
      end
    end
  end

  initial begin
    logic [31:0] t;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    model_reset();
    #2;
    do_reset();

    // Free-running fetch from reset.
    repeat (4) step(0, 0, 0);
    cmp("plan_addr10", Addr, 32'h10);
    cmp("plan_cnt4", FetchCount, 32'd4);
    cmp("plan_idpc_c", IdPc, 32'hC);

    // Stall with pc=8 for three cycles, then release.
    do_reset();
    repeat (2) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    cmp("stall_addr", Addr, 32'h8);
    cmp("stall_idpc", IdPc, 32'h4);
    step(0, 0, 0);
    cmp("release_idpc", IdPc, 32'h8);

    // Redirect from pc=C to 38: one bubble, then Rom[0E].
    step(0, 1, 32'h38);
    cmp("redir_addr", Addr, 32'h38);
    step(0, 0, 0);
    cmp("redir_inst", IdInst, rom[14]);
    cmp("redir_idpc", IdPc, 32'h38);

    // Redirect together with stall.
    step(1, 1, 32'h14);
    cmp("rs_addr", Addr, 32'h14);
    step(0, 0, 0);

    // Misaligned target: sticky error.
    step(0, 1, 32'h22);
    cmp("mis_addr", Addr, 32'h20);
    repeat (10) step(0, 0, 0);
    cmp("mis_sticky", {31'b0, AddrErr}, 32'h1);
    do_reset();

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    cmp("wrap_addr", Addr, 32'h0);
    cmp("wrap_p4", IdPcPlus4, 32'h0);

    // Asynchronous reset mid-cycle, checked before any further edge.
    step(0, 0, 0);
    #1 Clrn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    repeat (2) @(posedge Clk);
    #2 Clrn = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t);
    end

    @(posedge Clk);
    #3;
    cmp("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage for the single-issue pipelined CPU. It sits directly upstream of the combinational instruction ROM (`INSTMEM`, word-indexed by `Addr[6:2]`):
- drives the program counter onto `Addr`;
- captures the returned `Inst` into the IF/ID pipeline register;
- handles pipeline stalls and branch/jump redirects resolved by later stages.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, 32'h0000_0000: instruction word held in IF/ID when the register is empty or squashed.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Clrn`  in  1  asynchronous, active-low reset.
- `Addr`  out  32  current PC, combinationally equal to the PC register; connects to `INSTMEM.Addr`.
- `Inst`  in  32  instruction word from `INSTMEM`, valid in the same cycle as `Addr`.
- `Stall`  in  1  hold the PC and IF/ID register (load-use hazard from ID).
- `Redirect`  in  1  branch taken or jump resolved; replaces the next PC.
- `RedirectPc`  in  32  target address, used only when `Redirect`=1.
- `IdInst`  out  32  IF/ID instruction.
- `IdPc`  out  32  address `IdInst` was fetched from.
- `IdPcPlus4`  out  32  `IdPc` + 4, for branch-offset and link computation.
- `IdValid`  out  1  `IdInst` is a real, non-squashed instruction.
- `AddrErr`  out  1  sticky flag: a misaligned redirect target was received.
- `FetchCount`  out  32  number of instructions delivered to ID.

## Operation
- PC register `pc`. `Addr` = `pc`. PC increment is `pc + 4`, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0). The PC is never masked to ROM size; the ROM aliases every 128 bytes by itself.
- Next-state priority, evaluated each rising edge, highest first:
  1. `Redirect`=1 (overrides `Stall`):
     - `pc` <= {`RedirectPc`[31:2], 2'b00};
     - `IdInst` <= `NOP_INST`, `IdValid` <= 0; `IdPc` and `IdPcPlus4` hold;
     - if `RedirectPc`[1:0] != 0, then `AddrErr` <= 1.
  2. `Stall`=1: `pc`, `IdInst`, `IdPc`, `IdPcPlus4`, `IdValid` all hold.
  3. Otherwise:
     - `IdInst` <= `Inst`, `IdPc` <= `pc`, `IdPcPlus4` <= `pc`+4, `IdValid` <= 1;
     - `pc` <= `pc`+4.
- `FetchCount` increments by 1 only on case 3 edges, and wraps modulo 2^32.
- `AddrErr` is cleared only by reset.
- Reset (`Clrn`=0, asynchronous, takes effect immediately mid-cycle):
  - `pc`=`RESET_PC`, so `Addr`=`RESET_PC`;
  - `IdInst`=`NOP_INST`, `IdPc`=0, `IdPcPlus4`=0, `IdValid`=0;
  - `AddrErr`=0, `FetchCount`=0.
- Reset deassertion is synchronous to `Clk` at the system level. The first edge after release performs a normal fetch of `RESET_PC`.

## Timing
- Fetch latency is 1 cycle. The instruction at address A appears on `IdInst` one edge after `Addr`=A, provided `Stall`=0 and `Redirect`=0.
- A redirect costs exactly 1 bubble:
  - edge N: `Redirect`=1, so `IdValid`=0 and `pc`=target;
  - edge N+1: `IdInst`=Rom[target], `IdValid`=1.
- `Stall` held for k cycles freezes all outputs for k edges. Fetch resumes on the first edge with `Stall`=0, re-fetching the same `pc`.
- `Redirect` and `Stall` in the same cycle: the redirect is taken and the IF/ID register is squashed. ID must not depend on the held instruction after a redirect.
- `Addr` changes only on a clock edge or on reset assertion.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOP_INST`, `RESET_PC`, `PC_STEP`=4;
  - a 32-bit `word_t` typedef, also used by `INSTMEM`, decode and the register file.
- One sub-module, `if_id_reg`: the IF/ID pipeline register (`IdInst`, `IdPc`, `IdPcPlus4`, `IdValid`) with hold and squash inputs. `inst_fetch` contains the PC register, next-PC mux, `AddrErr` and `FetchCount`.

## Test plan
- Reset, then 4 free-running edges with the ROM preloaded:
  - `Addr` sequence is 0, 4, 8, C, 10;
  - `IdPc` sequence is 0, 4, 8, C;
  - `IdPcPlus4` is 4, 8, 10 (hex) as `IdPc` steps through 0, 4, C;
  - `IdValid`=1 from the first edge;
  - `FetchCount`=4.
- `Stall`=1 for 3 cycles while `pc`=8: `Addr` stays 8, `IdPc` stays 4, `FetchCount` is unchanged. When released, `IdPc`=8 on the next edge.
- `Redirect`=1 with `RedirectPc`=32'h38 while `pc`=C:
  - next edge: `Addr`=38, `IdValid`=0, `IdInst`=`NOP_INST`;
  - following edge: `IdInst`=Rom[0E], `IdPc`=38, `IdValid`=1.
- `Redirect` and `Stall` both =1 with `RedirectPc`=32'h14: redirect wins, so `Addr`=14 and `IdValid`=0. `FetchCount` is unchanged.
- `Redirect` with `RedirectPc`=32'h22: `Addr`=20 and `AddrErr`=1. `AddrErr` stays 1 across 10 further normal fetches and clears only after `Clrn` pulses low.
- Force `pc`=32'hFFFF_FFFC and run 1 edge: `Addr`=0 and `IdPcPlus4`=0. Then assert `Clrn`=0 mid-cycle: all outputs return to reset values immediately, without waiting for `Clk`.
